// File: rtl/countdown_timer_ctrl.sv
// countdown_timer_ctrl: keypad entry, load and tick sequencer for a cascaded BCD countdown chain.
// Define COUNTDOWN_TIMER_CTRL_ALARM_BLINK_EN to blink alarm in DONE from the free-running prescaler.
module countdown_timer_ctrl #(
  parameter int TICK_DIV   = 10,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_valid,
  input  logic [3:0]              key_data,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    clear,
  input  logic                    chain_tout,
  output logic [4*NUM_DIGITS-1:0] digit_data,
  output logic [NUM_DIGITS-1:0]   digit_load,
  output logic                    dec_pulse,
  output logic                    chain_noborrow,
  output logic [3:0]              entry_cnt,
  output logic                    running,
  output logic                    done,
  output logic                    alarm
);
  localparam int BW = 4 * NUM_DIGITS;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TC = PW'(TICK_DIV - 1);
  localparam logic [3:0] ND = 4'(NUM_DIGITS);
  typedef enum logic [2:0] {IDLE, ENTRY, LOAD, RUN, PAUSE, DONE} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] buf_q, buf_d;
  logic [3:0] cnt_q, cnt_d;
  logic [PW-1:0] pre_q, pre_d;
  logic running_q, done_q, alarm_q, alarm_d;
  logic tc, go, key_ok;
  assign tc = pre_q == TC;
  assign go = start && !stop;
  assign key_ok = key_valid && !start && !stop && key_data <= 4'd9 && cnt_q < ND &&
                  (state_q == IDLE || state_q == ENTRY);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q   <= IDLE;
      buf_q     <= '0;
      cnt_q     <= '0;
      pre_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      pre_q     <= pre_d;
      running_q <= state_d == RUN;
      done_q    <= state_d == DONE;
      alarm_q   <= alarm_d;
    end
  always_comb begin
    state_d = state_q;
    if (clear) state_d = IDLE;
    else
      case (state_q)
        IDLE, ENTRY: state_d = (go && |buf_q) ? LOAD : key_ok ? ENTRY : state_q;
        LOAD:        state_d = RUN;
        RUN:         state_d = stop ? PAUSE : chain_tout ? DONE : RUN;
        PAUSE:       state_d = go ? RUN : PAUSE;
        DONE:        state_d = go ? LOAD : DONE;
        default:     state_d = IDLE;
      endcase
  end
  always_comb begin
    buf_d = clear ? '0 : key_ok ? (buf_q << 4) | BW'(key_data) : buf_q;
    cnt_d = clear ? '0 : cnt_q + 4'(key_ok);
    pre_d = '0;
    case (state_q)
      RUN:     pre_d = stop ? pre_q : (chain_tout || tc) ? '0 : pre_q + PW'(1);
      PAUSE:   pre_d = pre_q;
`ifdef COUNTDOWN_TIMER_CTRL_ALARM_BLINK_EN
      DONE:    pre_d = tc ? '0 : pre_q + PW'(1);
`endif
      default: pre_d = '0;
    endcase
    if (clear) pre_d = '0;
`ifdef COUNTDOWN_TIMER_CTRL_ALARM_BLINK_EN
    alarm_d = (state_q == DONE && state_d == DONE) ? alarm_q ^ tc : 1'b0;
`else
    alarm_d = state_d == DONE;
`endif
  end
  // A tick is withheld on any cycle that leaves RUN, so a paused or timed-out chain never sees it.
  always_comb begin
    digit_load = {NUM_DIGITS{state_q == LOAD}};
    dec_pulse  = state_q == RUN && tc && !clear && !stop && !chain_tout;
  end
  assign digit_data     = buf_q;
  assign chain_noborrow = 1'b1;
  assign entry_cnt      = cnt_q;
  assign running        = running_q;
  assign done           = done_q;
  assign alarm          = alarm_q;
endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// tb_countdown_timer_ctrl: directed and randomized checks of countdown_timer_ctrl against a
// digit-list / elapsed-time reference model.
module tb_countdown_timer_ctrl;
  localparam int TD = 10;
  localparam int ND = 4;
  logic clk = 0, rst = 0, key_valid = 0, start = 0, stop = 0, clear = 0, chain_tout = 0;
  logic [3:0] key_data = 0;
  logic [4*ND-1:0] digit_data;
  logic [ND-1:0] digit_load;
  logic dec_pulse, chain_noborrow, running, done, alarm;
  logic [3:0] entry_cnt;
  int checks = 0, errors = 0;
  typedef enum {M_IDLE, M_ENTRY, M_LOAD, M_RUN, M_PAUSE, M_DONE} mode_t;
  mode_t mode = M_IDLE;
  int digits[$];
  int ticks = 0;
  int dwell = 0;
  int pulses = 0;
  int lat;
  logic last_pulse = 0;

  countdown_timer_ctrl #(.TICK_DIV(TD), .NUM_DIGITS(ND)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_data(key_data), .start(start),
    .stop(stop), .clear(clear), .chain_tout(chain_tout), .digit_data(digit_data),
    .digit_load(digit_load), .dec_pulse(dec_pulse), .chain_noborrow(chain_noborrow),
    .entry_cnt(entry_cnt), .running(running), .done(done), .alarm(alarm)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1);
  end

  function automatic int value();
    int v = 0;
    foreach (digits[i]) v = v * 16 + digits[i];
    return v;
  endfunction

  function automatic bit exp_alarm();
`ifdef COUNTDOWN_TIMER_CTRL_ALARM_BLINK_EN
    return mode == M_DONE && (dwell / TD) % 2 == 1;
`else
    return mode == M_DONE;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit kv, input logic [3:0] kd, input bit st, input bit sp,
                      input bit cl, input bit to);
    bit pulse;
    @(negedge clk);
    key_valid = kv; key_data = kd; start = st; stop = sp; clear = cl; chain_tout = to;
    #1;
    pulse = mode == M_RUN && !cl && !sp && !to && ticks % TD == TD - 1;
    last_pulse = dec_pulse;
    if (dec_pulse === 1'b1) pulses++;
    chk("digit_data", digit_data, value());
    chk("entry_cnt", entry_cnt, digits.size());
    chk("digit_load", digit_load, mode == M_LOAD ? {ND{1'b1}} : '0);
    chk("dec_pulse", dec_pulse, pulse);
    chk("running", running, mode == M_RUN);
    chk("done", done, mode == M_DONE);
    chk("alarm", alarm, exp_alarm());
    chk("chain_noborrow", chain_noborrow, 1);
    if (cl) begin
      mode = M_IDLE;
      digits.delete();
    end else
      case (mode)
        M_IDLE, M_ENTRY:
          if (st && !sp) begin
            if (value() != 0) mode = M_LOAD;
          end else if (kv && !sp && kd <= 9 && digits.size() < ND) begin
            digits.push_back(int'(kd));
            mode = M_ENTRY;
          end
        M_LOAD: begin mode = M_RUN; ticks = 0; end
        M_RUN:
          if (sp) mode = M_PAUSE;
          else if (to) begin mode = M_DONE; dwell = 0; end
          else ticks++;
        M_PAUSE: if (st && !sp) mode = M_RUN;
        M_DONE: if (st && !sp) mode = M_LOAD; else dwell++;
        default: mode = M_IDLE;
      endcase
    @(posedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic key(input logic [3:0] d);
    step(1, d, 0, 0, 0, 0);
  endtask

  task automatic run_until(input int p);
    for (int i = 0; i < 3 * TD && !(mode == M_RUN && ticks % TD == p); i++) idle();
  endtask

  task automatic reset_check(input string tag);
    key_valid = 0; key_data = 0; start = 0; stop = 0; clear = 0; chain_tout = 0;
    #2 rst = 0;
    #1;
    chk({tag, "_digit_data"}, digit_data, 0);
    chk({tag, "_entry_cnt"}, entry_cnt, 0);
    chk({tag, "_digit_load"}, digit_load, 0);
    chk({tag, "_dec_pulse"}, dec_pulse, 0);
    chk({tag, "_running"}, running, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_alarm"}, alarm, 0);
    chk({tag, "_noborrow"}, chain_noborrow, 1);
    mode = M_IDLE;
    digits.delete();
    ticks = 0;
    @(negedge clk) rst = 1;
  endtask

  initial begin
    bit kv, st, sp, cl, to;
    logic [3:0] kd;
    reset_check("por");
    key(1); key(2); key(12); key(3);
    #1;
    chk("entry_cnt_3", entry_cnt, 3);
    chk("entry_data_0123", digit_data, 16'h0123);
    step(0, 0, 1, 0, 0, 0);
    pulses = 0;
    idle();
    repeat (35) idle();
    chk("pulses_in_35", pulses, 3);
    run_until(5);
    reset_check("mid_run");
    key(9); key(8); key(7); key(6); key(5);
    #1;
    chk("overflow_data", digit_data, 16'h9876);
    chk("overflow_cnt", entry_cnt, 4);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0, 0);
    idle();
    chk("zero_start_load", digit_load, 0);
    chk("zero_start_running", running, 0);
    key(1); key(2); key(3);
    step(0, 0, 1, 0, 0, 0);
    run_until(4);
    pulses = 0;
    repeat (20) step(0, 0, 0, 1, 0, 0);
    chk("pause_pulses", pulses, 0);
    step(0, 0, 1, 0, 0, 0);
    lat = -1;
    for (int k = 1; k <= 15 && lat < 0; k++) begin
      idle();
      if (last_pulse === 1'b1) lat = k;
    end
    chk("resume_latency", lat, 6);
    run_until(9);
    step(0, 0, 0, 0, 0, 1);
    chk("tout_pulse", last_pulse, 0);
    #1 chk("done_next", done, 1);
    repeat (25) idle();
    step(1, 4, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    #1;
    chk("reload_load", digit_load, 4'hf);
    chk("reload_data", digit_data, 16'h0123);
    repeat (5) idle();
    #1 chk("reload_running", running, 1);
    step(0, 0, 1, 1, 1, 0);
    #1;
    chk("prio_running", running, 0);
    chk("prio_data", digit_data, 0);
    chk("prio_cnt", entry_cnt, 0);
    repeat (400) begin
      kv = $urandom_range(0, 9) < 4;
      kd = 4'($urandom_range(0, 15));
      st = $urandom_range(0, 19) == 0;
      sp = $urandom_range(0, 24) == 0;
      cl = $urandom_range(0, 49) == 0;
      to = $urandom_range(0, 39) == 0;
      step(kv, kd, st, sp, cl, to);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
